// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
//
// Holds the per-lane state encoding, the default configuration used by the
// top level, and the helper that derives the rescale shift from the input
// and output fixed-point formats.
//
// Optional feature macro: PSUM_ACC_ROUND_EN (round-half-up on rescale).
package psum_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } lane_state_t;

    localparam int DEF_LANES          = 4;
    localparam int DEF_DATA_WIDTH_IN  = 16;
    localparam int DEF_FRAC_BITS_IN   = 12;
    localparam int DEF_ACC_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH_OUT = 16;
    localparam int DEF_FRAC_BITS_OUT  = 12;
    localparam int DEF_MAX_BEATS      = 64;
    localparam int DEF_USER_WIDTH     = 8;

    // Number of fractional bits dropped when moving from the accumulator
    // format to the result format.
    function automatic int rescale_shift(input int frac_in, input int frac_out);
        return frac_in - frac_out;
    endfunction

endpackage

// File: rtl/psum_accumulator_lane.sv
// One accumulator lane: sums a tlast-delimited run of signed partial sums,
// rescales and saturates the total, and presents it as a single output beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   psum_data/valid/    incoming partial-sum stream (ready is driven here)
//   ready/last/user
//   res_data/valid/     outgoing result stream, one beat per run
//   ready/last/user
//   ovf_event           single-cycle pulse: accumulator clamped on this beat
//   run_err_event       single-cycle pulse: run forcibly closed at MAX_BEATS
//
// Optional feature macro: PSUM_ACC_ROUND_EN (round-half-up on rescale).
module psum_acc_lane
    import psum_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
    parameter int FRAC_BITS_IN   = DEF_FRAC_BITS_IN,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
    parameter int FRAC_BITS_OUT  = DEF_FRAC_BITS_OUT,
    parameter int MAX_BEATS      = DEF_MAX_BEATS,
    parameter int USER_WIDTH     = DEF_USER_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH_IN-1:0]  psum_data,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic                      psum_last,
    input  logic [USER_WIDTH-1:0]     psum_user,
    output logic [DATA_WIDTH_OUT-1:0] res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_last,
    output logic [USER_WIDTH-1:0]     res_user,
    output logic                      ovf_event,
    output logic                      run_err_event
);

    localparam int SHIFT = rescale_shift(FRAC_BITS_IN, FRAC_BITS_OUT);
    localparam int CW    = $clog2(MAX_BEATS + 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_WIDTH:0]   OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH_OUT+2){1'b0}}, {(DATA_WIDTH_OUT-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0]   OUT_MIN = ~OUT_MAX;

`ifdef PSUM_ACC_ROUND_EN
    // Half of the weight of the lowest kept bit; evaluates to zero when no
    // bits are dropped, so a zero shift needs no special case.
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
`else
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = '0;
`endif

    lane_state_t                     state, state_next;
    logic                            live;
    logic signed [ACC_WIDTH-1:0]     acc, acc_next;
    logic [CW-1:0]                   cnt, cnt_next;
    logic [USER_WIDTH-1:0]           run_user_q, run_user_next;
    logic [DATA_WIDTH_OUT-1:0]       out_q, out_next;
    logic [USER_WIDTH-1:0]           out_user_q, out_user_next;

    logic signed [ACC_WIDTH:0]       sum_wide;
    logic                            acc_ovf;
    logic signed [ACC_WIDTH-1:0]     sum_sat;
    logic signed [ACC_WIDTH:0]       biased;
    logic signed [ACC_WIDTH:0]       scaled;
    logic [DATA_WIDTH_OUT-1:0]       result;
    logic                            in_hs;
    logic                            out_hs;
    logic                            cap_hit;
    logic                            finish;

    // Registered state. The live flag keeps the input closed until the first
    // clock edge after reset has been released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            live       <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            run_user_q <= '0;
            out_q      <= '0;
            out_user_q <= '0;
        end else begin
            state      <= state_next;
            live       <= 1'b1;
            acc        <= acc_next;
            cnt        <= cnt_next;
            run_user_q <= run_user_next;
            out_q      <= out_next;
            out_user_q <= out_user_next;
        end
    end

    // Datapath: saturating add of the incoming beat, then rescale of that
    // same saturated total for the case where this beat closes the run.
    always_comb begin
        sum_wide = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-DATA_WIDTH_IN){psum_data[DATA_WIDTH_IN-1]}}, psum_data};
        acc_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
        if (!acc_ovf) begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            sum_sat = ACC_MIN;
        end else begin
            sum_sat = ACC_MAX;
        end
        biased = {sum_sat[ACC_WIDTH-1], sum_sat} + ROUND_BIAS;
        scaled = biased >>> SHIFT;
        if (scaled > OUT_MAX) begin
            result = OUT_MAX[DATA_WIDTH_OUT-1:0];
        end else if (scaled < OUT_MIN) begin
            result = OUT_MIN[DATA_WIDTH_OUT-1:0];
        end else begin
            result = scaled[DATA_WIDTH_OUT-1:0];
        end
    end

    // Next-state logic. While a result is held, the input is only opened when
    // that result leaves in the same cycle, so a new run can start with no
    // bubble. A closing beat (tlast or the beat cap) always lands in HOLD.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        cnt_next      = cnt;
        run_user_next = run_user_q;
        out_next      = out_q;
        out_user_next = out_user_q;

        psum_ready    = live & ((state == ACCUM) | res_ready);
        in_hs         = psum_valid & psum_ready;
        out_hs        = (state == HOLD) & res_ready;
        cap_hit       = (cnt == CW'(MAX_BEATS - 1));
        finish        = psum_last | cap_hit;

        if (in_hs) begin
            if (cnt == '0) begin
                run_user_next = psum_user;
            end
            if (finish) begin
                out_next      = result;
                out_user_next = (cnt == '0) ? psum_user : run_user_q;
                acc_next      = '0;
                cnt_next      = '0;
                state_next    = HOLD;
            end else begin
                acc_next      = sum_sat;
                cnt_next      = cnt + CW'(1);
                state_next    = ACCUM;
            end
        end else if (out_hs) begin
            state_next = ACCUM;
        end

        ovf_event     = in_hs & acc_ovf;
        run_err_event = in_hs & cap_hit & ~psum_last;
    end

    assign res_valid = (state == HOLD);
    assign res_last  = (state == HOLD);
    assign res_data  = out_q;
    assign res_user  = out_user_q;

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for the linear processing array.
//
// Each of LANES independent lanes sums its tlast-delimited run of signed
// partial sums, rescales the total to the output format, saturates it and
// emits it as one AXI-Stream beat. Lanes are not aligned with each other.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/   per-lane partial-sum input, lane k at
//   tlast/tuser                   [k*W +: W]
//   m_axis_tdata/tvalid/tready/   per-lane result output, tlast always set
//   tlast/tuser                   with tvalid, tuser from run's first beat
//   err_overflow                  sticky: some lane accumulator saturated
//   err_run_length                sticky: some run hit MAX_BEATS without tlast
//
// Optional feature macro: PSUM_ACC_ROUND_EN (round-half-up on rescale).
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int LANES          = DEF_LANES,
    parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
    parameter int FRAC_BITS_IN   = DEF_FRAC_BITS_IN,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
    parameter int FRAC_BITS_OUT  = DEF_FRAC_BITS_OUT,
    parameter int MAX_BEATS      = DEF_MAX_BEATS,
    parameter int USER_WIDTH     = DEF_USER_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [LANES*DATA_WIDTH_IN-1:0]  s_axis_tdata,
    input  logic [LANES-1:0]                s_axis_tvalid,
    output logic [LANES-1:0]                s_axis_tready,
    input  logic [LANES-1:0]                s_axis_tlast,
    input  logic [LANES*USER_WIDTH-1:0]     s_axis_tuser,
    output logic [LANES*DATA_WIDTH_OUT-1:0] m_axis_tdata,
    output logic [LANES-1:0]                m_axis_tvalid,
    input  logic [LANES-1:0]                m_axis_tready,
    output logic [LANES-1:0]                m_axis_tlast,
    output logic [LANES*USER_WIDTH-1:0]     m_axis_tuser,
    output logic                            err_overflow,
    output logic                            err_run_length
);

    logic [LANES-1:0] ovf_events;
    logic [LANES-1:0] run_err_events;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        psum_acc_lane #(
            .DATA_WIDTH_IN  (DATA_WIDTH_IN),
            .FRAC_BITS_IN   (FRAC_BITS_IN),
            .ACC_WIDTH      (ACC_WIDTH),
            .DATA_WIDTH_OUT (DATA_WIDTH_OUT),
            .FRAC_BITS_OUT  (FRAC_BITS_OUT),
            .MAX_BEATS      (MAX_BEATS),
            .USER_WIDTH     (USER_WIDTH)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .psum_data     (s_axis_tdata[k*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
            .psum_valid    (s_axis_tvalid[k]),
            .psum_ready    (s_axis_tready[k]),
            .psum_last     (s_axis_tlast[k]),
            .psum_user     (s_axis_tuser[k*USER_WIDTH +: USER_WIDTH]),
            .res_data      (m_axis_tdata[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
            .res_valid     (m_axis_tvalid[k]),
            .res_ready     (m_axis_tready[k]),
            .res_last      (m_axis_tlast[k]),
            .res_user      (m_axis_tuser[k*USER_WIDTH +: USER_WIDTH]),
            .ovf_event     (ovf_events[k]),
            .run_err_event (run_err_events[k])
        );
    end

    // Error flags collect the per-lane pulses and stay set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow   <= 1'b0;
            err_run_length <= 1'b0;
        end else begin
            err_overflow   <= err_overflow | (|ovf_events);
            err_run_length <= err_run_length | (|run_err_events);
        end
    end

endmodule
